// File: rtl/cpu_bus_ctrl_if.sv
// cpu_bus_ctrl_if
// Bundles the CPU-side access port, the memory-fabric request port and the
// status outputs of cpu_bus_ctrl.
//   CPU side    : i_bus_clk (strobe), i_bus_we, i_bus_addr, i_bus_data,
//                 o_bus_data, o_bus_data_ready
//   Fabric side : o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
//                 i_mem_ack, i_mem_rdata
//   Status      : o_busy, o_timeout_err, o_timeout_cnt
// The slave modport is the controller's view; master is the environment's view.
interface cpu_bus_ctrl_if;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned TCNT_W = 8;

   logic              i_bus_clk;
   logic              i_bus_we;
   logic [ADDR_W-1:0] i_bus_addr;
   logic [DATA_W-1:0] i_bus_data;
   logic [DATA_W-1:0] o_bus_data;
   logic              o_bus_data_ready;

   logic              o_mem_req;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              i_mem_ack;
   logic [DATA_W-1:0] i_mem_rdata;

   logic              o_busy;
   logic              o_timeout_err;
   logic [TCNT_W-1:0] o_timeout_cnt;

   modport slave (
      input  i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
      input  i_mem_ack, i_mem_rdata,
      output o_bus_data, o_bus_data_ready,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
      output o_busy, o_timeout_err, o_timeout_cnt
   );

   modport master (
      output i_bus_clk, i_bus_we, i_bus_addr, i_bus_data,
      output i_mem_ack, i_mem_rdata,
      input  o_bus_data, o_bus_data_ready,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
      input  o_busy, o_timeout_err, o_timeout_cnt
   );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl
// Bridges single-cycle CPU access strobes onto a request/acknowledge memory
// fabric. One transaction in flight at a time; a transaction that receives no
// acknowledge within TIMEOUT cycles is aborted, returning ERR_DATA on reads
// and recording the event in a sticky flag and a saturating counter.
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - cpu_bus_ctrl_if.slave (CPU port, fabric port, status)
// Parameters:
//   TIMEOUT  - cycles allowed in WAIT_ACK before abort (1..65535)
//   ERR_DATA - read data returned on a timed-out read
module cpu_bus_ctrl #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic           i_clk,
   input  logic           i_rst,
   cpu_bus_ctrl_if.slave  bus
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned WCNT_W = 16;
   localparam int unsigned TCNT_W = 8;

   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
   localparam logic [TCNT_W-1:0] TCNT_MAX  = '1;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_ACK = 2'd1;
   localparam logic [1:0] DONE     = 2'd2;

   logic [1:0]        state_q,     state_d;
   logic [WCNT_W-1:0] wait_cnt_q,  wait_cnt_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] bus_data_q,  bus_data_d;
   logic              ready_q,     ready_d;
   logic              busy_q,      busy_d;
   logic              terr_q,      terr_d;
   logic [TCNT_W-1:0] tcnt_q,      tcnt_d;

   // State and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         wait_cnt_q  <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         bus_data_q  <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         terr_q      <= 1'b0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         bus_data_q  <= bus_data_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         terr_q      <= terr_d;
         tcnt_q      <= tcnt_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      bus_data_d  = bus_data_q;
      ready_d     = 1'b0;
      terr_d      = terr_q;
      tcnt_d      = tcnt_q;

      case (state_q)
         IDLE: begin
            if (bus.i_bus_clk) begin
               state_d     = WAIT_ACK;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.i_bus_we;
               mem_addr_d  = bus.i_bus_addr;
               mem_wdata_d = bus.i_bus_data;
               wait_cnt_d  = '0;
            end
         end

         WAIT_ACK: begin
            // Cannot wrap: the timeout exit fires at TIMEOUT-1 <= 65534
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            // Ack is checked first so it wins over a same-cycle timeout
            if (bus.i_mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               ready_d   = 1'b1;
               if (!mem_we_q) begin
                  bus_data_d = bus.i_mem_rdata;
               end
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               ready_d   = 1'b1;
               terr_d    = 1'b1;
               if (!mem_we_q) begin
                  bus_data_d = ERR_DATA;
               end
               if (tcnt_q != TCNT_MAX) begin
                  tcnt_d = tcnt_q + TCNT_W'(1);
               end
            end
         end

         DONE: begin
            // Ready pulse is already registered for this cycle
            state_d = IDLE;
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.o_bus_data       = bus_data_q;
   assign bus.o_bus_data_ready = ready_q;
   assign bus.o_mem_req        = mem_req_q;
   assign bus.o_mem_we         = mem_we_q;
   assign bus.o_mem_addr       = mem_addr_q;
   assign bus.o_mem_wdata      = mem_wdata_q;
   assign bus.o_busy           = busy_q;
   assign bus.o_timeout_err    = terr_q;
   assign bus.o_timeout_cnt    = tcnt_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb_cpu_bus_ctrl
// Scenario-per-task bench for cpu_bus_ctrl with TIMEOUT=4. Expected read-back
// values are queued when each transaction is issued and popped when the
// ready pulse is observed.
module tb_cpu_bus_ctrl;

   localparam int unsigned TB_TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst;

   cpu_bus_ctrl_if bus();

   int checks       = 0;
   int failures     = 0;
   int ready_pulses = 0;
   int req_cycles   = 0;

   logic [31:0] exp_q[$];

   cpu_bus_ctrl #(
      .TIMEOUT  (TB_TIMEOUT),
      .ERR_DATA (32'hFFFF_FFFF)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Activity counters sampled mid-cycle
   always @(negedge clk) begin
      if (bus.o_bus_data_ready === 1'b1) ready_pulses++;
      if (bus.o_mem_req === 1'b1)        req_cycles++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic we, input logic [31:0] addr, input logic [31:0] data);
      bus.i_bus_clk  = 1'b1;
      bus.i_bus_we   = we;
      bus.i_bus_addr = addr;
      bus.i_bus_data = data;
      tick();
      bus.i_bus_clk  = 1'b0;
      bus.i_bus_we   = 1'b0;
      bus.i_bus_addr = '0;
      bus.i_bus_data = '0;
   endtask

   task automatic ack(input logic [31:0] rdata);
      bus.i_mem_ack   = 1'b1;
      bus.i_mem_rdata = rdata;
      tick();
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = '0;
   endtask

   // Bounded wait for the ready pulse; returns on the negedge it is seen
   task automatic wait_ready(input int max_cycles, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cycles && !seen; i++) begin
         @(negedge clk);
         if (bus.o_bus_data_ready === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      checks++;
      if ({bus.o_mem_req, bus.o_bus_data_ready, bus.o_mem_we, bus.o_busy, bus.o_timeout_err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {bus.o_mem_req, bus.o_bus_data_ready, bus.o_mem_we, bus.o_busy, bus.o_timeout_err});
      end
      checks++;
      if (bus.o_bus_data !== 32'h0) begin
         failures++;
         $display("FAIL reset_bus_data: got %h expected 00000000", bus.o_bus_data);
      end
      checks++;
      if ({bus.o_mem_addr, bus.o_mem_wdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_mem_addr_wdata: got %h %h expected 0 0", bus.o_mem_addr, bus.o_mem_wdata);
      end
      checks++;
      if (bus.o_timeout_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset_timeout_cnt: got %0d expected 0", bus.o_timeout_cnt);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_zero_wait();
      int p0;
      bit seen;
      logic [31:0] exp;
      p0 = ready_pulses;
      exp_q.push_back(32'hCAFE_F00D);
      strobe(1'b0, 32'h0000_1234, 32'h0);
      @(negedge clk);
      checks++;
      if ({bus.o_mem_req, bus.o_mem_we, bus.o_busy, bus.o_mem_addr} !== {3'b101, 32'h0000_1234}) begin
         failures++;
         $display("FAIL read_req: got req=%b we=%b busy=%b addr=%h expected 1 0 1 00001234",
                  bus.o_mem_req, bus.o_mem_we, bus.o_busy, bus.o_mem_addr);
      end
      ack(32'hCAFE_F00D);
      wait_ready(1, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL read_latency: got no ready at strobe+2 expected ready");
      end else if (bus.o_bus_data !== exp) begin
         failures++;
         $display("FAIL read_data: got %h expected %h", bus.o_bus_data, exp);
      end
      tick();
      tick();
      checks++;
      if (ready_pulses - p0 !== 1 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL read_single_pulse: got pulses=%0d busy=%b expected 1 0", ready_pulses - p0, bus.o_busy);
      end
   endtask

   task automatic test_write_delay();
      int p0, r0;
      bit seen;
      logic [31:0] exp;
      p0 = ready_pulses;
      r0 = req_cycles;
      exp_q.push_back(32'hCAFE_F00D);
      strobe(1'b1, 32'h0000_0010, 32'h55AA_55AA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !==
             {2'b11, 32'h0000_0010, 32'h55AA_55AA}) begin
            failures++;
            $display("FAIL write_latched[%0d]: got req=%b we=%b addr=%h wdata=%h expected 1 1 00000010 55aa55aa",
                     i, bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
         end
         if (i < 2) tick();
      end
      ack(32'hDEAD_BEEF);
      wait_ready(1, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL write_ready: got no ready expected ready");
      end else if (bus.o_bus_data !== exp) begin
         failures++;
         $display("FAIL write_bus_data_kept: got %h expected %h", bus.o_bus_data, exp);
      end
      tick();
      tick();
      checks++;
      if (req_cycles - r0 !== 3 || ready_pulses - p0 !== 1) begin
         failures++;
         $display("FAIL write_counts: got req_cycles=%0d pulses=%0d expected 3 1",
                  req_cycles - r0, ready_pulses - p0);
      end
   endtask

   task automatic test_ack_final_cycle();
      int r0;
      bit seen;
      logic [31:0] exp;
      r0 = req_cycles;
      exp_q.push_back(32'h1357_9BDF);
      strobe(1'b0, 32'h0000_2000, 32'h0);
      repeat (TB_TIMEOUT - 1) tick();
      ack(32'h1357_9BDF);
      wait_ready(1, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL final_ack_ready: got no ready expected ready");
      end else if (bus.o_bus_data !== exp) begin
         failures++;
         $display("FAIL final_ack_data: got %h expected %h", bus.o_bus_data, exp);
      end
      checks++;
      if (bus.o_timeout_err !== 1'b0 || bus.o_timeout_cnt !== 8'd0) begin
         failures++;
         $display("FAIL final_ack_no_err: got err=%b cnt=%0d expected 0 0", bus.o_timeout_err, bus.o_timeout_cnt);
      end
      tick();
      checks++;
      if (req_cycles - r0 !== 4) begin
         failures++;
         $display("FAIL final_ack_req_cycles: got %0d expected 4", req_cycles - r0);
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      bit seen;
      logic [31:0] exp;
      p0 = ready_pulses;
      exp_q.push_back(32'h0BAD_F00D);
      strobe(1'b0, 32'h0000_A000, 32'h0);
      strobe(1'b1, 32'h0000_B000, 32'h1111_1111);
      @(negedge clk);
      checks++;
      if (bus.o_mem_addr !== 32'h0000_A000 || bus.o_mem_we !== 1'b0) begin
         failures++;
         $display("FAIL b2b_addr_kept: got addr=%h we=%b expected 0000a000 0", bus.o_mem_addr, bus.o_mem_we);
      end
      ack(32'h0BAD_F00D);
      wait_ready(1, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL b2b_ready: got no ready expected ready");
      end else if (bus.o_bus_data !== exp) begin
         failures++;
         $display("FAIL b2b_data: got %h expected %h", bus.o_bus_data, exp);
      end
      // Strobe during DONE must be dropped
      strobe(1'b1, 32'h0000_C000, 32'h2222_2222);
      @(negedge clk);
      checks++;
      if (bus.o_mem_req !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_mem_addr !== 32'h0000_A000) begin
         failures++;
         $display("FAIL done_strobe_ignored: got req=%b busy=%b addr=%h expected 0 0 0000a000",
                  bus.o_mem_req, bus.o_busy, bus.o_mem_addr);
      end
      // Stray ack while idle must not complete anything
      ack(32'h7777_7777);
      @(negedge clk);
      checks++;
      if (bus.o_bus_data_ready !== 1'b0 || bus.o_bus_data !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL idle_ack_ignored: got ready=%b data=%h expected 0 0badf00d",
                  bus.o_bus_data_ready, bus.o_bus_data);
      end
      tick();
      checks++;
      if (ready_pulses - p0 !== 1) begin
         failures++;
         $display("FAIL b2b_single_pulse: got %0d expected 1", ready_pulses - p0);
      end
   endtask

   task automatic test_read_timeout();
      int p0, r0;
      bit seen;
      logic [31:0] exp;
      p0 = ready_pulses;
      r0 = req_cycles;
      exp_q.push_back(32'hFFFF_FFFF);
      strobe(1'b0, 32'h0000_3000, 32'h0);
      wait_ready(TB_TIMEOUT + 2, seen);
      exp = exp_q.pop_front();
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL timeout_ready: got no ready within budget expected ready");
      end else if (bus.o_bus_data !== exp) begin
         failures++;
         $display("FAIL timeout_data: got %h expected %h", bus.o_bus_data, exp);
      end
      checks++;
      if (bus.o_timeout_err !== 1'b1 || bus.o_timeout_cnt !== 8'd1) begin
         failures++;
         $display("FAIL timeout_flags: got err=%b cnt=%0d expected 1 1", bus.o_timeout_err, bus.o_timeout_cnt);
      end
      tick();
      tick();
      checks++;
      if (req_cycles - r0 !== 4 || ready_pulses - p0 !== 1) begin
         failures++;
         $display("FAIL timeout_counts: got req_cycles=%0d pulses=%0d expected 4 1",
                  req_cycles - r0, ready_pulses - p0);
      end
   endtask

   task automatic test_reset_mid_wait();
      int p0;
      p0 = ready_pulses;
      strobe(1'b1, 32'h0000_4000, 32'h9999_9999);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ack(32'h5555_5555);
      @(negedge clk);
      checks++;
      if ({bus.o_mem_req, bus.o_bus_data_ready, bus.o_mem_we, bus.o_busy, bus.o_timeout_err} !== 5'b0 ||
          bus.o_timeout_cnt !== 8'd0) begin
         failures++;
         $display("FAIL midreset_flags: got req=%b rdy=%b we=%b busy=%b err=%b cnt=%0d expected all 0",
                  bus.o_mem_req, bus.o_bus_data_ready, bus.o_mem_we, bus.o_busy,
                  bus.o_timeout_err, bus.o_timeout_cnt);
      end
      checks++;
      if ({bus.o_bus_data, bus.o_mem_addr, bus.o_mem_wdata} !== 96'h0) begin
         failures++;
         $display("FAIL midreset_data: got data=%h addr=%h wdata=%h expected 0 0 0",
                  bus.o_bus_data, bus.o_mem_addr, bus.o_mem_wdata);
      end
      tick();
      tick();
      checks++;
      if (ready_pulses - p0 !== 0) begin
         failures++;
         $display("FAIL midreset_no_pulse: got %0d expected 0", ready_pulses - p0);
      end
      // Reset wins over a same-cycle strobe
      rst = 1'b1;
      strobe(1'b0, 32'h0000_5000, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_mem_req !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_mem_addr !== 32'h0) begin
         failures++;
         $display("FAIL reset_beats_strobe: got req=%b busy=%b addr=%h expected 0 0 0",
                  bus.o_mem_req, bus.o_busy, bus.o_mem_addr);
      end
      tick();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 255; i++) begin
         strobe(1'b0, 32'h0000_6000, 32'h0);
         repeat (TB_TIMEOUT + 1) tick();
      end
      @(negedge clk);
      checks++;
      if (bus.o_timeout_cnt !== 8'd255 || bus.o_timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL sat_reach: got cnt=%0d err=%b expected 255 1", bus.o_timeout_cnt, bus.o_timeout_err);
      end
      strobe(1'b0, 32'h0000_6004, 32'h0);
      repeat (TB_TIMEOUT + 1) tick();
      @(negedge clk);
      checks++;
      if (bus.o_timeout_cnt !== 8'd255) begin
         failures++;
         $display("FAIL sat_hold: got cnt=%0d expected 255", bus.o_timeout_cnt);
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.i_bus_clk   = 1'b0;
      bus.i_bus_we    = 1'b0;
      bus.i_bus_addr  = '0;
      bus.i_bus_data  = '0;
      bus.i_mem_ack   = 1'b0;
      bus.i_mem_rdata = '0;

      test_reset();
      test_read_zero_wait();
      test_write_delay();
      test_ack_final_cycle();
      test_back_to_back();
      test_read_timeout();
      test_reset_mid_wait();
      test_saturation();

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
